// File: rtl/clock_set_controller.sv
// Time-setting sequencer: MODE steps RUN -> SET_HOURS -> SET_MINUTES -> RUN.
// ADJUST gives one increment per tap, or auto-repeat (slow, then fast) while held.
module clock_set_controller #(
    parameter int HOLD_TICKS = 4,
    parameter int FAST_TICKS = 8,
    parameter int TIMEOUT_S  = 10,
    parameter int TO_W       = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_mode_btn,
    input  logic i_adj_btn,
    input  logic i_1hz_stb,
    input  logic i_slow_set_stb,
    input  logic i_fast_set_stb,
    output logic o_set_hours,
    output logic o_set_minutes,
    output logic o_set_stb,
    output logic o_sec_clear,
    output logic o_blink_hours,
    output logic o_blink_minutes
);

    typedef enum logic [1:0] {
        MAIN_RUN     = 2'd0,
        MAIN_HOURS   = 2'd1,
        MAIN_MINUTES = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        REP_IDLE = 2'd0,
        REP_WAIT = 2'd1,
        REP_SLOW = 2'd2,
        REP_FAST = 2'd3
    } rep_state_t;

    localparam int TK_MAX = (HOLD_TICKS > FAST_TICKS) ? HOLD_TICKS : FAST_TICKS;
    localparam int TK_W   = $clog2(TK_MAX + 1);

    localparam logic [TK_W-1:0] HOLD_LAST = TK_W'(HOLD_TICKS - 1);
    localparam logic [TK_W-1:0] FAST_LAST = TK_W'(FAST_TICKS - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_S);

    logic        mode_prev_r;
    logic        adj_prev_r;
    logic        mode_rise_r;
    logic        adj_rise_r;
    main_state_t main_r;
    rep_state_t  rep_r;
    logic [TK_W-1:0] tick_r;
    logic [TO_W-1:0] to_cnt_r;
    logic        toggle_r;
    logic        adjusted_r;

    logic        in_set_s;
    logic        any_rise_s;
    logic        to_hit_s;
    logic        main_chg_s;
    main_state_t main_nxt_s;
    rep_state_t  rep_nxt_s;
    logic [TK_W-1:0] tick_nxt_s;
    logic [TO_W-1:0] to_inc_s;
    logic [TO_W-1:0] to_nxt_s;
    logic        toggle_nxt_s;
    logic        adjusted_nxt_s;
    logic        stb_nxt_s;
    logic        sec_clr_nxt_s;

    // Next-state logic; button levels and rises are seen one cycle after sampling.
    always_comb begin
        in_set_s   = (main_r != MAIN_RUN);
        any_rise_s = mode_rise_r | adj_rise_r;

        to_inc_s = to_cnt_r;
        if (!in_set_s || any_rise_s || adj_prev_r) begin
            to_inc_s = '0;
        end else if (i_1hz_stb && (to_cnt_r != TO_LIMIT)) begin
            to_inc_s = to_cnt_r + TO_W'(1);
        end else begin
            to_inc_s = to_cnt_r;
        end
        to_hit_s = in_set_s && (to_inc_s == TO_LIMIT);

        main_nxt_s = main_r;
        if (mode_rise_r) begin
            case (main_r)
                MAIN_RUN:     main_nxt_s = MAIN_HOURS;
                MAIN_HOURS:   main_nxt_s = MAIN_MINUTES;
                MAIN_MINUTES: main_nxt_s = MAIN_RUN;
                default:      main_nxt_s = MAIN_RUN;
            endcase
        end else if (to_hit_s) begin
            main_nxt_s = MAIN_RUN;
        end else begin
            main_nxt_s = main_r;
        end
        main_chg_s = (main_nxt_s != main_r);
        to_nxt_s   = (main_nxt_s == MAIN_RUN) ? '0 : to_inc_s;

        // A MODE change pre-empts any ADJUST activity in the same cycle.
        rep_nxt_s  = rep_r;
        tick_nxt_s = tick_r;
        stb_nxt_s  = 1'b0;
        if (main_chg_s || (main_nxt_s == MAIN_RUN) || !adj_prev_r) begin
            rep_nxt_s  = REP_IDLE;
            tick_nxt_s = '0;
        end else begin
            case (rep_r)
                REP_IDLE: begin
                    if (adj_rise_r) begin
                        stb_nxt_s  = 1'b1;
                        rep_nxt_s  = REP_WAIT;
                        tick_nxt_s = '0;
                    end else begin
                        rep_nxt_s = REP_IDLE;
                    end
                end
                REP_WAIT: begin
                    if (!i_slow_set_stb) begin
                        tick_nxt_s = tick_r;
                    end else if (tick_r == HOLD_LAST) begin
                        rep_nxt_s  = REP_SLOW;
                        tick_nxt_s = '0;
                    end else begin
                        tick_nxt_s = tick_r + TK_W'(1);
                    end
                end
                REP_SLOW: begin
                    if (!i_slow_set_stb) begin
                        tick_nxt_s = tick_r;
                    end else if (tick_r == FAST_LAST) begin
                        stb_nxt_s  = 1'b1;
                        rep_nxt_s  = REP_FAST;
                        tick_nxt_s = '0;
                    end else begin
                        stb_nxt_s  = 1'b1;
                        tick_nxt_s = tick_r + TK_W'(1);
                    end
                end
                REP_FAST: begin
                    stb_nxt_s = i_fast_set_stb;
                end
                default: begin
                    rep_nxt_s  = REP_IDLE;
                    tick_nxt_s = '0;
                end
            endcase
        end

        sec_clr_nxt_s = (main_r == MAIN_MINUTES) && (main_nxt_s == MAIN_RUN) && adjusted_r;

        if (main_nxt_s == MAIN_RUN) begin
            adjusted_nxt_s = 1'b0;
        end else if (stb_nxt_s) begin
            adjusted_nxt_s = 1'b1;
        end else begin
            adjusted_nxt_s = adjusted_r;
        end

        if (main_chg_s || (main_nxt_s == MAIN_RUN)) begin
            toggle_nxt_s = 1'b0;
        end else if (i_1hz_stb) begin
            toggle_nxt_s = ~toggle_r;
        end else begin
            toggle_nxt_s = toggle_r;
        end
    end

    // State, counters, edge detectors and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_prev_r     <= 1'b0;
            adj_prev_r      <= 1'b0;
            mode_rise_r     <= 1'b0;
            adj_rise_r      <= 1'b0;
            main_r          <= MAIN_RUN;
            rep_r           <= REP_IDLE;
            tick_r          <= '0;
            to_cnt_r        <= '0;
            toggle_r        <= 1'b0;
            adjusted_r      <= 1'b0;
            o_set_hours     <= 1'b0;
            o_set_minutes   <= 1'b0;
            o_set_stb       <= 1'b0;
            o_sec_clear     <= 1'b0;
            o_blink_hours   <= 1'b0;
            o_blink_minutes <= 1'b0;
        end else begin
            mode_prev_r     <= i_mode_btn;
            adj_prev_r      <= i_adj_btn;
            mode_rise_r     <= i_mode_btn & ~mode_prev_r;
            adj_rise_r      <= i_adj_btn & ~adj_prev_r;
            main_r          <= main_nxt_s;
            rep_r           <= rep_nxt_s;
            tick_r          <= tick_nxt_s;
            to_cnt_r        <= to_nxt_s;
            toggle_r        <= toggle_nxt_s;
            adjusted_r      <= adjusted_nxt_s;
            o_set_hours     <= (main_nxt_s == MAIN_HOURS);
            o_set_minutes   <= (main_nxt_s == MAIN_MINUTES);
            o_set_stb       <= stb_nxt_s;
            o_sec_clear     <= sec_clr_nxt_s;
            o_blink_hours   <= (main_nxt_s == MAIN_HOURS) && toggle_nxt_s && (rep_nxt_s == REP_IDLE);
            o_blink_minutes <= (main_nxt_s == MAIN_MINUTES) && toggle_nxt_s && (rep_nxt_s == REP_IDLE);
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random stimulus,
// every cycle compared against an event-level reference model.
module tb_clock_set_controller;

    localparam int HOLD_TICKS = 4;
    localparam int FAST_TICKS = 8;
    localparam int TIMEOUT_S  = 10;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    logic i_mode_btn = 1'b0;
    logic i_adj_btn = 1'b0;
    logic i_1hz_stb = 1'b0;
    logic i_slow_set_stb = 1'b0;
    logic i_fast_set_stb = 1'b0;
    logic o_set_hours;
    logic o_set_minutes;
    logic o_set_stb;
    logic o_sec_clear;
    logic o_blink_hours;
    logic o_blink_minutes;

    int checks = 0;
    int errors = 0;
    int stb_seen = 0;
    int clr_seen = 0;
    logic mode_b = 1'b0;
    logic adj_b = 1'b0;

    // Reference model: mode 0=RUN 1=HOURS 2=MINUTES; session = an ADJUST hold in progress.
    int   m_mode, m_nslow, m_idle;
    logic m_sess, m_tog, m_adjf;
    logic h1m, h2m, h1a, h2a;
    logic exp_h, exp_m, exp_stb, exp_clr, exp_bh, exp_bm;

    clock_set_controller dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_mode_btn     (i_mode_btn),
        .i_adj_btn      (i_adj_btn),
        .i_1hz_stb      (i_1hz_stb),
        .i_slow_set_stb (i_slow_set_stb),
        .i_fast_set_stb (i_fast_set_stb),
        .o_set_hours    (o_set_hours),
        .o_set_minutes  (o_set_minutes),
        .o_set_stb      (o_set_stb),
        .o_sec_clear    (o_sec_clear),
        .o_blink_hours  (o_blink_hours),
        .o_blink_minutes(o_blink_minutes)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_nslow = 0; m_idle = 0;
        m_sess = 1'b0; m_tog = 1'b0; m_adjf = 1'b0;
        h1m = 1'b0; h2m = 1'b0; h1a = 1'b0; h2a = 1'b0;
        exp_h = 1'b0; exp_m = 1'b0; exp_stb = 1'b0; exp_clr = 1'b0; exp_bh = 1'b0; exp_bm = 1'b0;
    endtask

    // One clock edge of the reference, fed the same inputs the DUT samples.
    task automatic model_step(input logic m, input logic a, input logic hz, input logic sl, input logic fa);
        logic rise_m, rise_a, lvl, stb, clr;
        int   nm;
        rise_m = h1m & ~h2m;
        rise_a = h1a & ~h2a;
        lvl    = h1a;
        nm = rise_m ? (m_mode + 1) % 3 : m_mode;
        if (!rise_m && m_mode != 0 && !rise_a && !lvl && hz && (m_idle + 1 >= TIMEOUT_S))
            nm = 0;
        if (nm == 0 || m_mode == 0 || rise_m || rise_a || lvl) m_idle = 0;
        else if (hz && m_idle < TIMEOUT_S) m_idle++;
        stb = 1'b0;
        if (nm != m_mode || nm == 0 || !lvl) begin
            m_sess = 1'b0; m_nslow = 0;
        end else if (!m_sess) begin
            if (rise_a) begin stb = 1'b1; m_sess = 1'b1; m_nslow = 0; end
        end else if (m_nslow >= HOLD_TICKS + FAST_TICKS) begin
            stb = fa;
        end else if (sl) begin
            m_nslow++;
            stb = (m_nslow > HOLD_TICKS);
        end
        clr = (m_mode == 2) && (nm == 0) && m_adjf;
        if (nm == 0) m_adjf = 1'b0;
        else if (stb) m_adjf = 1'b1;
        if (nm != m_mode || nm == 0) m_tog = 1'b0;
        else if (hz) m_tog = ~m_tog;
        exp_h = (nm == 1); exp_m = (nm == 2);
        exp_stb = stb; exp_clr = clr;
        exp_bh = (nm == 1) && m_tog && !m_sess;
        exp_bm = (nm == 2) && m_tog && !m_sess;
        m_mode = nm;
        h2m = h1m; h1m = m; h2a = h1a; h1a = a;
    endtask

    task automatic step(input logic hz, input logic sl, input logic fa);
        i_mode_btn = mode_b; i_adj_btn = adj_b;
        i_1hz_stb = hz; i_slow_set_stb = sl; i_fast_set_stb = fa;
        @(posedge i_clk);
        model_step(mode_b, adj_b, hz, sl, fa);
        @(negedge i_clk);
        check("set_hours", o_set_hours, exp_h);
        check("set_minutes", o_set_minutes, exp_m);
        check("set_stb", o_set_stb, exp_stb);
        check("sec_clear", o_sec_clear, exp_clr);
        check("blink_hours", o_blink_hours, exp_bh);
        check("blink_minutes", o_blink_minutes, exp_bm);
        stb_seen += int'(o_set_stb);
        clr_seen += int'(o_sec_clear);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_mode();
        mode_b = 1'b1; idle(2);
        mode_b = 1'b0; idle(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hours"}, o_set_hours, 1'b0);
        check({tag, "_minutes"}, o_set_minutes, 1'b0);
        check({tag, "_stb"}, o_set_stb, 1'b0);
        check({tag, "_clr"}, o_sec_clear, 1'b0);
        check({tag, "_bh"}, o_blink_hours, 1'b0);
        check({tag, "_bm"}, o_blink_minutes, 1'b0);
    endtask

    // Asynchronous reset taken between clock edges; called at a falling edge.
    task automatic do_reset();
        #1 i_reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        check_all_zero("reset");
        i_reset_n = 1'b1;
        idle(2);

        // MODE walk with two-cycle latency
        mode_b = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("hours_lat1", o_set_hours, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("hours_lat2", o_set_hours, 1'b1);
        mode_b = 1'b0; idle(2);
        press_mode();
        check("minutes_on", o_set_minutes, 1'b1);
        press_mode();
        check("back_run", o_set_minutes, 1'b0);

        // SET_HOURS short tap
        press_mode();
        stb_seen = 0;
        adj_b = 1'b1; idle(2);
        adj_b = 1'b0; idle(3);
        check("tap_count", stb_seen, 1);

        // SET_MINUTES hold through slow and fast phases
        press_mode();
        stb_seen = 0;
        adj_b = 1'b1; idle(3);
        for (int i = 0; i < HOLD_TICKS + FAST_TICKS + 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        check("hold_count", stb_seen, 1 + FAST_TICKS + 6);
        adj_b = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        // inactivity timeout after adjustment
        clr_seen = 0;
        for (int i = 0; i < TIMEOUT_S; i++) begin
            step(1'b1, 1'b0, 1'b0);
            idle(2);
        end
        check("timeout_clr", clr_seen, 1);
        check("timeout_run", o_set_minutes, 1'b0);

        // same timeout without adjustment
        press_mode();
        press_mode();
        clr_seen = 0;
        for (int i = 0; i < TIMEOUT_S; i++) begin
            step(1'b1, 1'b0, 1'b0);
            idle(2);
        end
        check("noadj_clr", clr_seen, 0);
        check("noadj_run", o_set_minutes, 1'b0);

        // MODE and ADJUST rising together in SET_HOURS
        press_mode();
        stb_seen = 0;
        mode_b = 1'b1; adj_b = 1'b1; idle(3);
        mode_b = 1'b0; adj_b = 1'b0; idle(2);
        check("simul_minutes", o_set_minutes, 1'b1);
        check("simul_stb", stb_seen, 0);

        // reset during fast repeat, ADJUST ignored afterwards
        press_mode();
        press_mode();
        adj_b = 1'b1; idle(2);
        for (int i = 0; i < HOLD_TICKS + FAST_TICKS + 1; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        do_reset();
        stb_seen = 0;
        idle(3);
        adj_b = 1'b0; idle(2);
        adj_b = 1'b1; idle(3);
        adj_b = 1'b0; idle(2);
        check("post_rst_stb", stb_seen, 0);
        check("post_rst_run", o_set_hours, 1'b0);

        // randomized segments with varied strobe and button rates
        for (int seg = 0; seg < 8; seg++) begin
            int hz_div, adj_div, mode_div;
            hz_div   = int'($urandom_range(2, 30));
            adj_div  = int'($urandom_range(4, 40));
            mode_div = int'($urandom_range(20, 200));
            for (int c = 0; c < 400; c++) begin
                logic hz, sl, fa;
                if ($urandom_range(0, mode_div - 1) == 0) mode_b = ~mode_b;
                if ($urandom_range(0, adj_div - 1) == 0) adj_b = ~adj_b;
                hz = ($urandom_range(0, hz_div - 1) == 0);
                sl = ($urandom_range(0, 3) == 0);
                fa = ($urandom_range(0, 1) == 1);
                step(hz, sl, fa);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
